id_ex_hazard_stage: RTL and testbench
=====================================

Name: id_ex_hazard_stage

Overview:
ID/EX pipeline register plus load-use hazard detection for the 5-stage RISC-V core. Captures the decoder's control bundle, operands, immediate and register addresses each cycle. Detects a load in EX whose rd feeds the instruction in ID, and generates the NoOp request for Control, plus the PC and IF/ID write-enables. Inserts bubbles on hazard or flush, holds on external stall, and keeps saturating stall/bubble counters for debug.

Parameters:
XLEN, 32, datapath width
RA_W, 5, register address width
CNT_W, 16, width of debug counters

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous reset, active-low
ctrl_i  in  8  control bundle {Branch, MemWrite, MemRead, MemtoReg, RegWrite, ALUsrc, ALUop[1:0]}
rs1_data_i  in  XLEN  register-file read data 1
rs2_data_i  in  XLEN  register-file read data 2
imm_i  in  XLEN  sign-extended immediate
pc_i  in  XLEN  PC of ID instruction
funct_i  in  10  {funct7, funct3}
rs1_i, rs2_i, rd_i  in  RA_W each  ID register addresses
uses_rs1_i, uses_rs2_i  in  1 each  ID instruction reads rs1/rs2
stall_i  in  1  external stall (memory not ready): hold everything
flush_i  in  1  branch taken: kill ID instruction
noop_o  out  1  to Control NoOp: load-use hazard this cycle
pc_write_o  out  1  PC write enable
ifid_write_o  out  1  IF/ID write enable
ex_ctrl_o  out  8  registered control bundle
ex_rs1_data_o, ex_rs2_data_o, ex_imm_o, ex_pc_o  out  XLEN each  registered data
ex_funct_o  out  10  registered funct
ex_rs1_o, ex_rs2_o, ex_rd_o  out  RA_W each  registered addresses (for forwarding)
ex_valid_o  out  1  EX slot holds a real instruction
stall_cnt_o  out  CNT_W  cycles with hazard asserted
bubble_cnt_o  out  CNT_W  bubbles inserted (hazard or flush)

Behaviour:
- Reset (rst_i=0, asynchronous): all registered outputs 0, ex_valid_o=0, counters 0. Hazard logic sees ex_valid_o=0, so noop_o=0 and pc_write_o=ifid_write_o=1 while stall_i=0.
- hazard = ex_valid_o & ex_ctrl_o.MemRead & (ex_rd_o!=0) & ((uses_rs1_i & rs1_i==ex_rd_o) | (uses_rs2_i & rs2_i==ex_rd_o)). Combinational from registered state and ID inputs.
- noop_o = hazard & ~flush_i.
- pc_write_o = ifid_write_o = ~stall_i & ~noop_o.
- Register update per rising edge, in priority order:
  1. stall_i: hold all registers and counters. Stall overrides flush; the flush must be re-presented.
  2. flush_i: ex_ctrl_o=0, ex_valid_o=0, data fields captured (don't-care), bubble_cnt+1.
  3. hazard: ex_ctrl_o=0, ex_valid_o=0, bubble_cnt+1, stall_cnt+1.
  4. Otherwise: capture all inputs, ex_valid_o = (ctrl_i!=0).
- A hazard lasts exactly one cycle: after the bubble, ex_valid_o=0, so hazard drops. ID is re-presented because IF/ID was held.
- A flush coinciding with a hazard takes the flush path. noop_o stays 0 and PC/IF/ID advance to the branch target.
- ex_rd_o=0 never creates a hazard (x0).
- Counters saturate at all-ones and never wrap.
- Reset asserted mid-stall or mid-bubble clears everything immediately. No pending state survives reset.

Decomposition:
- Shared package cpu_pkg holds:
  - CTRL_W=8 and bit-index constants CTRL_BRANCH..CTRL_ALUOP_LSB;
  - opcode constants OP_RTYPE 0110011, OP_ITYPE 0010011, OP_LW 0000011, OP_SW 0100011, OP_BEQ 1100011;
  - typedef of the control bundle.
- One sub-module: sat_counter (CNT_W, inc, async active-low clear), instantiated twice.

Test Plan:
- Reset then idle: rst_i=0 → all ex_* = 0, ex_valid_o=0, noop_o=0, pc_write_o=1, counters 0.
- lw x5 in EX (ctrl MemRead=1, rd=5), ID add x6,x5,x7 (rs1=5, uses_rs1=1) → noop_o=1, pc_write_o=0 for 1 cycle. Next edge ex_ctrl_o=0, stall_cnt=1, bubble_cnt=1. Following cycle noop_o=0 and add captured.
- lw x0 in EX, ID reads rs1=0 → noop_o=0, no bubble.
- Hazard and flush_i=1 same cycle → noop_o=0, pc_write_o=1, ex_valid_o=0 next edge, bubble_cnt+1, stall_cnt unchanged.
- stall_i=1 for 3 cycles with valid sw in EX → ex_* and counters constant, pc_write_o=0. Release → normal capture.
- Force bubble_cnt to 16'hFFFF, then flush → stays 16'hFFFF.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared core definitions: control-bundle layout, opcodes and the
// update selector used by the ID/EX register.
package cpu_pkg;

   localparam int unsigned CTRL_W         = 8;
   localparam int unsigned CTRL_BRANCH    = 7;
   localparam int unsigned CTRL_MEMWRITE  = 6;
   localparam int unsigned CTRL_MEMREAD   = 5;
   localparam int unsigned CTRL_MEMTOREG  = 4;
   localparam int unsigned CTRL_REGWRITE  = 3;
   localparam int unsigned CTRL_ALUSRC    = 2;
   localparam int unsigned CTRL_ALUOP_MSB = 1;
   localparam int unsigned CTRL_ALUOP_LSB = 0;

   localparam logic [6:0] OP_RTYPE = 7'b0110011;
   localparam logic [6:0] OP_ITYPE = 7'b0010011;
   localparam logic [6:0] OP_LW    = 7'b0000011;
   localparam logic [6:0] OP_SW    = 7'b0100011;
   localparam logic [6:0] OP_BEQ   = 7'b1100011;

   typedef struct packed {
      logic       branch;
      logic       mem_write;
      logic       mem_read;
      logic       mem_to_reg;
      logic       reg_write;
      logic       alu_src;
      logic [1:0] alu_op;
   } ctrl_t;

   typedef enum logic [1:0] {
      UPD_HOLD,
      UPD_FLUSH,
      UPD_BUBBLE,
      UPD_CAPTURE
   } upd_e;

endpackage

// File: rtl/id_ex_hazard_stage_if.sv
// ID-side inputs, hazard handshake and EX-side outputs of the ID/EX stage.
interface id_ex_hazard_stage_if #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned RA_W  = 5,
   parameter int unsigned CNT_W = 16
);
   import cpu_pkg::*;

   logic [CTRL_W-1:0] ctrl_i;
   logic [XLEN-1:0]   rs1_data_i;
   logic [XLEN-1:0]   rs2_data_i;
   logic [XLEN-1:0]   imm_i;
   logic [XLEN-1:0]   pc_i;
   logic [9:0]        funct_i;
   logic [RA_W-1:0]   rs1_i;
   logic [RA_W-1:0]   rs2_i;
   logic [RA_W-1:0]   rd_i;
   logic              uses_rs1_i;
   logic              uses_rs2_i;
   logic              stall_i;
   logic              flush_i;

   logic              noop_o;
   logic              pc_write_o;
   logic              ifid_write_o;
   logic [CTRL_W-1:0] ex_ctrl_o;
   logic [XLEN-1:0]   ex_rs1_data_o;
   logic [XLEN-1:0]   ex_rs2_data_o;
   logic [XLEN-1:0]   ex_imm_o;
   logic [XLEN-1:0]   ex_pc_o;
   logic [9:0]        ex_funct_o;
   logic [RA_W-1:0]   ex_rs1_o;
   logic [RA_W-1:0]   ex_rs2_o;
   logic [RA_W-1:0]   ex_rd_o;
   logic              ex_valid_o;
   logic [CNT_W-1:0]  stall_cnt_o;
   logic [CNT_W-1:0]  bubble_cnt_o;

   modport master (
      output ctrl_i, rs1_data_i, rs2_data_i, imm_i, pc_i, funct_i,
             rs1_i, rs2_i, rd_i, uses_rs1_i, uses_rs2_i, stall_i, flush_i,
      input  noop_o, pc_write_o, ifid_write_o, ex_ctrl_o, ex_rs1_data_o,
             ex_rs2_data_o, ex_imm_o, ex_pc_o, ex_funct_o, ex_rs1_o,
             ex_rs2_o, ex_rd_o, ex_valid_o, stall_cnt_o, bubble_cnt_o
   );

   modport slave (
      input  ctrl_i, rs1_data_i, rs2_data_i, imm_i, pc_i, funct_i,
             rs1_i, rs2_i, rd_i, uses_rs1_i, uses_rs2_i, stall_i, flush_i,
      output noop_o, pc_write_o, ifid_write_o, ex_ctrl_o, ex_rs1_data_o,
             ex_rs2_data_o, ex_imm_o, ex_pc_o, ex_funct_o, ex_rs1_o,
             ex_rs2_o, ex_rd_o, ex_valid_o, stall_cnt_o, bubble_cnt_o
   );

endinterface

// File: rtl/id_ex_hazard_stage_sat_counter.sv
// Saturating up-counter with asynchronous active-low clear; sticks at all-ones.
module sat_counter #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             inc_i,
   output logic [CNT_W-1:0] cnt_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (inc_i && (cnt_q != '1)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/id_ex_hazard_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion
// on hazard or branch flush, external stall hold and debug counters.
module id_ex_hazard_stage
   import cpu_pkg::*;
#(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned RA_W  = 5,
   parameter int unsigned CNT_W = 16
) (
   input logic                 clk_i,
   input logic                 rst_i,
   id_ex_hazard_stage_if.slave bus
);

   ctrl_t           ctrl_q,     ctrl_d;
   logic [XLEN-1:0] rs1_data_q, rs1_data_d;
   logic [XLEN-1:0] rs2_data_q, rs2_data_d;
   logic [XLEN-1:0] imm_q,      imm_d;
   logic [XLEN-1:0] pc_q,       pc_d;
   logic [9:0]      funct_q,    funct_d;
   logic [RA_W-1:0] rs1_q,      rs1_d;
   logic [RA_W-1:0] rs2_q,      rs2_d;
   logic [RA_W-1:0] rd_q,       rd_d;
   logic            valid_q,    valid_d;

   logic hazard;
   logic noop;
   upd_e upd;

   // x0 as a load destination never stalls the consumer.
   always_comb begin
      hazard = valid_q & ctrl_q.mem_read & (rd_q != '0) &
               ((bus.uses_rs1_i & (bus.rs1_i == rd_q)) |
                (bus.uses_rs2_i & (bus.rs2_i == rd_q)));
      noop   = hazard & ~bus.flush_i;
   end

   always_comb begin
      if (bus.stall_i) begin
         upd = UPD_HOLD;
      end else if (bus.flush_i) begin
         upd = UPD_FLUSH;
      end else if (hazard) begin
         upd = UPD_BUBBLE;
      end else begin
         upd = UPD_CAPTURE;
      end
   end

   always_comb begin
      ctrl_d     = ctrl_q;
      rs1_data_d = rs1_data_q;
      rs2_data_d = rs2_data_q;
      imm_d      = imm_q;
      pc_d       = pc_q;
      funct_d    = funct_q;
      rs1_d      = rs1_q;
      rs2_d      = rs2_q;
      rd_d       = rd_q;
      valid_d    = valid_q;
      if (upd != UPD_HOLD) begin
         rs1_data_d = bus.rs1_data_i;
         rs2_data_d = bus.rs2_data_i;
         imm_d      = bus.imm_i;
         pc_d       = bus.pc_i;
         funct_d    = bus.funct_i;
         rs1_d      = bus.rs1_i;
         rs2_d      = bus.rs2_i;
         rd_d       = bus.rd_i;
      end
      case (upd)
         UPD_FLUSH, UPD_BUBBLE: begin
            ctrl_d  = '0;
            valid_d = 1'b0;
         end
         UPD_CAPTURE: begin
            ctrl_d  = ctrl_t'(bus.ctrl_i);
            valid_d = (bus.ctrl_i != '0);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         ctrl_q     <= '0;
         rs1_data_q <= '0;
         rs2_data_q <= '0;
         imm_q      <= '0;
         pc_q       <= '0;
         funct_q    <= '0;
         rs1_q      <= '0;
         rs2_q      <= '0;
         rd_q       <= '0;
         valid_q    <= 1'b0;
      end else begin
         ctrl_q     <= ctrl_d;
         rs1_data_q <= rs1_data_d;
         rs2_data_q <= rs2_data_d;
         imm_q      <= imm_d;
         pc_q       <= pc_d;
         funct_q    <= funct_d;
         rs1_q      <= rs1_d;
         rs2_q      <= rs2_d;
         rd_q       <= rd_d;
         valid_q    <= valid_d;
      end
   end

   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .inc_i (upd == UPD_BUBBLE),
      .cnt_o (bus.stall_cnt_o)
   );

   sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .inc_i ((upd == UPD_BUBBLE) || (upd == UPD_FLUSH)),
      .cnt_o (bus.bubble_cnt_o)
   );

   assign bus.noop_o        = noop;
   assign bus.pc_write_o    = ~bus.stall_i & ~noop;
   assign bus.ifid_write_o  = ~bus.stall_i & ~noop;
   assign bus.ex_ctrl_o     = ctrl_q;
   assign bus.ex_rs1_data_o = rs1_data_q;
   assign bus.ex_rs2_data_o = rs2_data_q;
   assign bus.ex_imm_o      = imm_q;
   assign bus.ex_pc_o       = pc_q;
   assign bus.ex_funct_o    = funct_q;
   assign bus.ex_rs1_o      = rs1_q;
   assign bus.ex_rs2_o      = rs2_q;
   assign bus.ex_rd_o       = rd_q;
   assign bus.ex_valid_o    = valid_q;

endmodule

// File: tb/tb_id_ex_hazard_stage.sv
// Scoreboard bench for id_ex_hazard_stage: stimulus pushes expected responses
// from a behavioural model, a negedge monitor pops and compares them.
module tb_id_ex_hazard_stage;
   import cpu_pkg::*;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned RA_W  = 5;
   localparam int unsigned CNT_W = 8;
   localparam int unsigned CMAX  = (1 << CNT_W) - 1;

   localparam logic [7:0] C_LW  = 8'h3C; // MemRead MemtoReg RegWrite ALUsrc
   localparam logic [7:0] C_ADD = 8'h0A; // RegWrite ALUop=10
   localparam logic [7:0] C_SW  = 8'h44; // MemWrite ALUsrc
   localparam logic [7:0] C_BEQ = 8'h81; // Branch ALUop=01

   logic clk_i = 1'b0;
   logic rst_i = 1'b0;
   always #5 clk_i = ~clk_i;

   id_ex_hazard_stage_if #(.XLEN(XLEN), .RA_W(RA_W), .CNT_W(CNT_W)) bus ();

   id_ex_hazard_stage #(.XLEN(XLEN), .RA_W(RA_W), .CNT_W(CNT_W)) dut (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .bus   (bus)
   );

   typedef struct {
      logic        noop;
      logic        pcw;
      logic [7:0]  ctrl;
      logic        valid;
      logic        chk_data;
      logic [31:0] rs1d, rs2d, imm, pc;
      logic [9:0]  funct;
      logic [4:0]  rs1, rs2, rd;
      int unsigned scnt, bcnt;
   } exp_t;

   exp_t sb_q[$];
   int   errors = 0;
   int   checks = 0;

   // Reference state of the EX slot
   logic        m_valid;
   logic [7:0]  m_ctrl;
   logic        m_chk;
   logic [31:0] m_rs1d, m_rs2d, m_imm, m_pc;
   logic [9:0]  m_funct;
   logic [4:0]  m_rs1, m_rs2, m_rd;
   int unsigned m_scnt, m_bcnt;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_valid = 1'b0; m_ctrl = '0; m_chk = 1'b1;
      m_rs1d = '0; m_rs2d = '0; m_imm = '0; m_pc = '0; m_funct = '0;
      m_rs1 = '0; m_rs2 = '0; m_rd = '0; m_scnt = 0; m_bcnt = 0;
   endtask

   task automatic cycle(input logic rst, input logic [7:0] ctrl,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic u1, input logic u2, input logic st, input logic fl);
      exp_t        e;
      logic        hz;
      logic [31:0] d1, d2, im, pcv;
      logic [9:0]  fn;
      d1 = $urandom; d2 = $urandom; im = $urandom; pcv = $urandom; fn = 10'($urandom);
      @(posedge clk_i);
      #1;
      rst_i = rst;
      bus.ctrl_i = ctrl; bus.rs1_i = rs1; bus.rs2_i = rs2; bus.rd_i = rd;
      bus.uses_rs1_i = u1; bus.uses_rs2_i = u2; bus.stall_i = st; bus.flush_i = fl;
      bus.rs1_data_i = d1; bus.rs2_data_i = d2; bus.imm_i = im; bus.pc_i = pcv;
      bus.funct_i = fn;
      if (!rst) model_reset();
      hz = m_valid && m_ctrl[CTRL_MEMREAD] && (m_rd != 0) &&
           ((u1 && rs1 == m_rd) || (u2 && rs2 == m_rd));
      e.noop = hz && !fl;
      e.pcw  = !st && !e.noop;
      e.ctrl = m_ctrl; e.valid = m_valid; e.chk_data = m_chk;
      e.rs1d = m_rs1d; e.rs2d = m_rs2d; e.imm = m_imm; e.pc = m_pc; e.funct = m_funct;
      e.rs1 = m_rs1; e.rs2 = m_rs2; e.rd = m_rd; e.scnt = m_scnt; e.bcnt = m_bcnt;
      sb_q.push_back(e);
      if (rst && !st) begin
         if (fl || hz) begin
            m_ctrl = '0; m_valid = 1'b0; m_chk = 1'b0;
            m_bcnt = (m_bcnt + 1 > CMAX) ? CMAX : m_bcnt + 1;
            if (!fl) m_scnt = (m_scnt + 1 > CMAX) ? CMAX : m_scnt + 1;
         end else begin
            m_ctrl = ctrl; m_valid = (ctrl != 0); m_chk = 1'b1;
            m_rs1d = d1; m_rs2d = d2; m_imm = im; m_pc = pcv; m_funct = fn;
            m_rs1 = rs1; m_rs2 = rs2; m_rd = rd;
         end
      end
   endtask

   // Monitor: one response per cycle, sampled mid-cycle
   initial begin
      exp_t e;
      forever begin
         @(negedge clk_i);
         if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check("noop",       32'(bus.noop_o),       32'(e.noop));
            check("pc_write",   32'(bus.pc_write_o),   32'(e.pcw));
            check("ifid_write", 32'(bus.ifid_write_o), 32'(e.pcw));
            check("ex_ctrl",    32'(bus.ex_ctrl_o),    32'(e.ctrl));
            check("ex_valid",   32'(bus.ex_valid_o),   32'(e.valid));
            check("stall_cnt",  32'(bus.stall_cnt_o),  e.scnt);
            check("bubble_cnt", 32'(bus.bubble_cnt_o), e.bcnt);
            if (e.chk_data) begin
               check("ex_rs1_data", bus.ex_rs1_data_o, e.rs1d);
               check("ex_rs2_data", bus.ex_rs2_data_o, e.rs2d);
               check("ex_imm",      bus.ex_imm_o,      e.imm);
               check("ex_pc",       bus.ex_pc_o,       e.pc);
               check("ex_funct",    32'(bus.ex_funct_o), 32'(e.funct));
               check("ex_rs1",      32'(bus.ex_rs1_o), 32'(e.rs1));
               check("ex_rs2",      32'(bus.ex_rs2_o), 32'(e.rs2));
               check("ex_rd",       32'(bus.ex_rd_o),  32'(e.rd));
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic logic [7:0] rand_ctrl();
      case ($urandom_range(0, 4))
         0:       return 8'h00;
         1:       return C_LW;
         2:       return C_ADD;
         3:       return C_SW;
         default: return C_BEQ;
      endcase
   endfunction

   initial begin
      model_reset();
      bus.ctrl_i = '0; bus.rs1_i = '0; bus.rs2_i = '0; bus.rd_i = '0;
      bus.uses_rs1_i = 1'b0; bus.uses_rs2_i = 1'b0; bus.stall_i = 1'b0; bus.flush_i = 1'b0;
      bus.rs1_data_i = '0; bus.rs2_data_i = '0; bus.imm_i = '0; bus.pc_i = '0; bus.funct_i = '0;

      cycle(0, 8'h00, 0, 0, 0, 0, 0, 0, 0);
      cycle(0, C_ADD, 1, 2, 3, 1, 1, 0, 0);
      // lw x5 then dependent add: one bubble, add re-presented
      cycle(1, C_LW,  1, 0, 5, 1, 0, 0, 0);
      cycle(1, C_ADD, 5, 7, 6, 1, 1, 0, 0);
      cycle(1, C_ADD, 5, 7, 6, 1, 1, 0, 0);
      // lw x0 never stalls
      cycle(1, C_LW,  2, 0, 0, 1, 0, 0, 0);
      cycle(1, C_ADD, 0, 0, 8, 1, 1, 0, 0);
      // hazard coinciding with flush
      cycle(1, C_LW,  2, 0, 3, 1, 0, 0, 0);
      cycle(1, C_ADD, 4, 3, 9, 1, 1, 0, 1);
      cycle(1, C_ADD, 4, 3, 9, 1, 1, 0, 0);
      // stall with sw in EX, stall overriding flush, then release
      cycle(1, C_SW,  1, 2, 0, 1, 1, 0, 0);
      cycle(1, C_LW,  2, 2, 7, 1, 0, 1, 0);
      cycle(1, C_LW,  2, 2, 7, 1, 0, 1, 1);
      cycle(1, C_LW,  2, 2, 7, 1, 0, 1, 0);
      cycle(1, C_LW,  2, 2, 7, 1, 0, 0, 0);
      // stall while a hazard is pending, then reset mid-bubble
      cycle(1, C_ADD, 7, 1, 4, 1, 0, 1, 0);
      cycle(1, C_ADD, 7, 1, 4, 1, 0, 0, 0);
      cycle(0, C_ADD, 7, 1, 4, 1, 0, 0, 0);
      cycle(1, C_ADD, 7, 1, 4, 1, 0, 0, 0);

      for (int i = 0; i < 1500; i++) begin
         cycle(($urandom_range(0, 99) != 0), rand_ctrl(),
               5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
               1'($urandom), 1'($urandom),
               ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0));
      end

      // drive the bubble counter past all-ones
      for (int i = 0; i < CMAX + 20; i++) begin
         cycle(1, rand_ctrl(), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
               5'($urandom_range(0, 7)), 1'($urandom), 1'($urandom), 1'b0, 1'b1);
      end
      cycle(1, C_ADD, 1, 2, 3, 1, 1, 0, 1);

      @(negedge clk_i);
      #1;
      check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
      check("bubble_cnt_saturated", 32'(bus.bubble_cnt_o), CMAX);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
